// File: rtl/cmd_cfg.sv
// Command decoder and configuration state for the flight controller.
// Consumes UART command frames, holds setpoints, sequences calibration and battery reads.
module cmd_cfg #(
    parameter int FAST_SIM = 0,
    parameter int SPIN_W   = 26,
    parameter int WD_W     = 28
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_rdy,
    input  logic [7:0]         cmd,
    input  logic [15:0]        data,
    output logic               clr_cmd_rdy,
    output logic [7:0]         resp,
    output logic               send_resp,
    input  logic [7:0]         batt,
    output logic               strt_cnv,
    input  logic               cnv_cmplt,
    output logic signed [15:0] d_ptch,
    output logic signed [15:0] d_roll,
    output logic signed [15:0] d_yaw,
    output logic [8:0]         thrst,
    output logic               strt_cal,
    output logic               inertial_cal,
    input  logic               cal_done,
    output logic               motors_off
);

    localparam int SPIN_BITS = (FAST_SIM != 0) ? 9 : SPIN_W;
    localparam int WD_BITS   = (FAST_SIM != 0) ? 12 : WD_W;

    localparam logic [SPIN_BITS-1:0] SPIN_ONE = {{(SPIN_BITS-1){1'b0}}, 1'b1};
    localparam logic [WD_BITS-1:0]   WD_ONE   = {{(WD_BITS-1){1'b0}}, 1'b1};

    localparam logic [7:0] OP_REQ_BATT  = 8'h01;
    localparam logic [7:0] OP_SET_PTCH  = 8'h02;
    localparam logic [7:0] OP_SET_ROLL  = 8'h03;
    localparam logic [7:0] OP_SET_YAW   = 8'h04;
    localparam logic [7:0] OP_SET_THRST = 8'h05;
    localparam logic [7:0] OP_CALIBRATE = 8'h06;
    localparam logic [7:0] OP_EMER_LAND = 8'h07;
    localparam logic [7:0] OP_MTRS_OFF  = 8'h08;

    localparam logic [7:0] RESP_ACK  = 8'hA5;
    localparam logic [7:0] RESP_NACK = 8'hEE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPIN,
        ST_CAL,
        ST_BATT,
        ST_RESP
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [15:0]          r_ptch;
    logic [15:0]          r_roll;
    logic [15:0]          r_yaw;
    logic [8:0]           r_thrst;
    logic                 r_motors_off;
    logic [7:0]           r_resp;
    logic                 r_strt_cnv;
    logic [SPIN_BITS-1:0] r_spin_cnt;
    logic [WD_BITS-1:0]   r_wd_cnt;
    logic                 r_wd_fired;

    logic w_accept;
    logic w_send_resp;
    logic w_strt_cal;
    logic w_inertial_cal;
    logic w_spin_tc;
    logic w_wd_tc;
    logic w_wd_expire;

    assign w_spin_tc = &r_spin_cnt;
    assign w_wd_tc   = &r_wd_cnt;

    // Watchdog zeroes the setpoints once per saturation; a command in the same cycle wins.
    assign w_wd_expire = (r_state == ST_IDLE) && w_wd_tc && !r_wd_fired && !w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_accept       = 1'b0;
        w_send_resp    = 1'b0;
        w_strt_cal     = 1'b0;
        w_inertial_cal = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_rdy) begin
                    w_accept = 1'b1;
                    case (cmd)
                        OP_REQ_BATT:  w_state_next = ST_BATT;
                        OP_CALIBRATE: w_state_next = ST_SPIN;
                        default:      w_state_next = ST_RESP;
                    endcase
                end
            end
            ST_SPIN: begin
                if (w_spin_tc) begin
                    w_strt_cal   = 1'b1;
                    w_state_next = ST_CAL;
                end
            end
            ST_CAL: begin
                w_inertial_cal = 1'b1;
                if (cal_done) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_BATT: begin
                if (cnv_cmplt) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                w_send_resp  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptch       <= '0;
            r_roll       <= '0;
            r_yaw        <= '0;
            r_thrst      <= '0;
            r_motors_off <= 1'b1;
        end else if (w_accept) begin
            case (cmd)
                OP_SET_PTCH:  r_ptch  <= data;
                OP_SET_ROLL:  r_roll  <= data;
                OP_SET_YAW:   r_yaw   <= data;
                OP_SET_THRST: r_thrst <= data[8:0];
                OP_CALIBRATE: begin
                    r_ptch       <= '0;
                    r_roll       <= '0;
                    r_yaw        <= '0;
                    r_thrst      <= '0;
                    r_motors_off <= 1'b0;
                end
                OP_EMER_LAND: begin
                    r_ptch  <= '0;
                    r_roll  <= '0;
                    r_yaw   <= '0;
                    r_thrst <= '0;
                end
                OP_MTRS_OFF: begin
                    r_motors_off <= 1'b1;
                    r_thrst      <= '0;
                end
                default: ;
            endcase
        end else if (w_wd_expire) begin
            r_ptch  <= '0;
            r_roll  <= '0;
            r_yaw   <= '0;
            r_thrst <= '0;
        end
    end

    // Response byte: ack/nack decided at acceptance, otherwise set when CAL or BATT finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp <= '0;
        end else if (w_accept) begin
            case (cmd)
                OP_REQ_BATT, OP_CALIBRATE: r_resp <= r_resp;
                OP_SET_PTCH, OP_SET_ROLL, OP_SET_YAW, OP_SET_THRST,
                OP_EMER_LAND, OP_MTRS_OFF: r_resp <= RESP_ACK;
                default:                   r_resp <= RESP_NACK;
            endcase
        end else if ((r_state == ST_CAL) && cal_done) begin
            r_resp <= RESP_ACK;
        end else if ((r_state == ST_BATT) && cnv_cmplt) begin
            r_resp <= batt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_strt_cnv <= 1'b0;
        end else begin
            r_strt_cnv <= w_accept && (cmd == OP_REQ_BATT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spin_cnt <= '0;
        end else if (w_accept && (cmd == OP_CALIBRATE)) begin
            r_spin_cnt <= '0;
        end else if (r_state == ST_SPIN) begin
            r_spin_cnt <= r_spin_cnt + SPIN_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd_cnt   <= '0;
            r_wd_fired <= 1'b0;
        end else if (w_accept) begin
            r_wd_cnt   <= '0;
            r_wd_fired <= 1'b0;
        end else begin
            if (!w_wd_tc) begin
                r_wd_cnt <= r_wd_cnt + WD_ONE;
            end
            if (w_wd_expire) begin
                r_wd_fired <= 1'b1;
            end
        end
    end

    assign clr_cmd_rdy  = w_accept;
    assign send_resp    = w_send_resp;
    assign strt_cal     = w_strt_cal;
    assign inertial_cal = w_inertial_cal;
    assign strt_cnv     = r_strt_cnv;
    assign resp         = r_resp;
    assign d_ptch       = r_ptch;
    assign d_roll       = r_roll;
    assign d_yaw        = r_yaw;
    assign thrst        = r_thrst;
    assign motors_off   = r_motors_off;

endmodule
